synaptic_sram_rmw_ctrl: RTL and testbench

//   Initiator side of the synaptic weight SRAM port (CS/WE/A/D/Q, 1-cycle synchronous read).

---
 rtl/synaptic_sram_rmw_ctrl.sv | 156 +++++++++++++++
 tb/tb_synaptic_sram_rmw_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/synaptic_sram_rmw_ctrl.sv
// Synaptic SRAM read-modify-write controller: single-word reads and saturating single-lane weight updates.
// Latency from the accept edge: a read response is captured at edge 3 and an update response at edge 4.
// REQ_READY is high only in IDLE. Responses have no backpressure: the consumer must capture RSP_DATA on the RSP_VALID cycle.
module synaptic_sram_rmw_ctrl #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int WEIGHT_WIDTH = 8,
    parameter int DELTA_WIDTH  = 8,
    parameter int LANE_WIDTH   = 2
) (
    input  logic                  CK,
    input  logic                  RST,
    // request channel
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_OP,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [LANE_WIDTH-1:0] REQ_LANE,
    input  logic [DELTA_WIDTH-1:0] REQ_DELTA,
    // response channel
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    // SRAM initiator port
    output logic                  SRAM_CS,
    output logic                  SRAM_WE,
    output logic [ADDR_WIDTH-1:0] SRAM_A,
    output logic [DATA_WIDTH-1:0] SRAM_D,
    input  logic [DATA_WIDTH-1:0] SRAM_Q
);

    // The sum is one bit wider than the widest operand, so the add itself never overflows.
    localparam int SUM_W = ((WEIGHT_WIDTH > DELTA_WIDTH) ? WEIGHT_WIDTH : DELTA_WIDTH) + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (WEIGHT_WIDTH - 1)) - 1);
    // In two's complement, ~x equals -x-1, so this gives -2^(WEIGHT_WIDTH-1).
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CALC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                  state;
    logic                    op_q;
    logic [LANE_WIDTH-1:0]   lane_q;
    logic [DELTA_WIDTH-1:0]  delta_q;
    logic [DATA_WIDTH-1:0]   word_q;

    logic [WEIGHT_WIDTH-1:0] lane_old;
    logic [WEIGHT_WIDTH-1:0] lane_new;
    logic signed [SUM_W-1:0] w_ext;
    logic signed [SUM_W-1:0] d_ext;
    logic signed [SUM_W-1:0] sum;
    logic [DATA_WIDTH-1:0]   new_word;
    int                      lane_base;

    // Merge the selected lane of the freshly read word with the saturated sum of weight and delta.
    // Every other lane passes through unchanged, and a read uses the word as stored.
    always_comb begin
        lane_base = int'(lane_q) * WEIGHT_WIDTH;
        lane_old  = SRAM_Q[lane_base +: WEIGHT_WIDTH];
        w_ext     = {{(SUM_W - WEIGHT_WIDTH){lane_old[WEIGHT_WIDTH-1]}}, lane_old};
        d_ext     = {{(SUM_W - DELTA_WIDTH){delta_q[DELTA_WIDTH-1]}}, delta_q};
        sum       = w_ext + d_ext;
        if (sum > SAT_MAX) begin
            lane_new = SAT_MAX[WEIGHT_WIDTH-1:0];
        end else if (sum < SAT_MIN) begin
            lane_new = SAT_MIN[WEIGHT_WIDTH-1:0];
        end else begin
            lane_new = sum[WEIGHT_WIDTH-1:0];
        end
        new_word = SRAM_Q;
        if (op_q) begin
            new_word[lane_base +: WEIGHT_WIDTH] = lane_new;
        end
    end

    // Control FSM. Every output is a register loaded on the transition into the state that owns it.
    // This avoids any combinational path from an input to an output.
    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= IDLE;
            op_q      <= 1'b0;
            lane_q    <= '0;
            delta_q   <= '0;
            word_q    <= '0;
            REQ_READY <= 1'b1;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            SRAM_CS   <= 1'b0;
            SRAM_WE   <= 1'b0;
            SRAM_A    <= '0;
            SRAM_D    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        op_q      <= REQ_OP;
                        lane_q    <= REQ_LANE;
                        delta_q   <= REQ_DELTA;
                        SRAM_A    <= REQ_ADDR;
                        SRAM_CS   <= 1'b1;
                        SRAM_WE   <= 1'b0;
                        REQ_READY <= 1'b0;
                        state     <= READ;
                    end
                end
                READ: begin
                    // The SRAM captures the read at this edge, and Q is valid in CALC.
                    SRAM_CS <= 1'b0;
                    state   <= CALC;
                end
                CALC: begin
                    word_q <= new_word;
                    if (op_q) begin
                        SRAM_CS <= 1'b1;
                        SRAM_WE <= 1'b1;
                        SRAM_D  <= new_word;
                        state   <= WRITE;
                    end else begin
                        RSP_VALID <= 1'b1;
                        RSP_DATA  <= new_word;
                        state     <= DONE;
                    end
                end
                WRITE: begin
                    SRAM_CS   <= 1'b0;
                    SRAM_WE   <= 1'b0;
                    RSP_VALID <= 1'b1;
                    RSP_DATA  <= word_q;
                    state     <= DONE;
                end
                DONE: begin
                    RSP_VALID <= 1'b0;
                    REQ_READY <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    SRAM_CS   <= 1'b0;
                    SRAM_WE   <= 1'b0;
                    RSP_VALID <= 1'b0;
                    REQ_READY <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // A write strobe without chip select would corrupt the macro's protocol.
    a_we_needs_cs: assert property (@(posedge CK) disable iff (RST) SRAM_WE |-> SRAM_CS);
    // A response is always a single-cycle pulse.
    a_rsp_pulse: assert property (@(posedge CK) disable iff (RST) RSP_VALID |=> !RSP_VALID);

endmodule

// File: tb/tb_synaptic_sram_rmw_ctrl.sv
// Directed bench for synaptic_sram_rmw_ctrl with a behavioural 1-cycle synchronous SRAM.
// Latency is reported as the index of the posedge that captures RSP_VALID (accept edge = 0).
// Inputs change on negedges and outputs are sampled on negedges.
module tb_synaptic_sram_rmw_ctrl;

    logic        CK = 1'b0;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_OP;
    logic [7:0]  REQ_ADDR;
    logic [1:0]  REQ_LANE;
    logic [7:0]  REQ_DELTA;
    logic        RSP_VALID;
    logic [31:0] RSP_DATA;
    logic        SRAM_CS;
    logic        SRAM_WE;
    logic [7:0]  SRAM_A;
    logic [31:0] SRAM_D;
    logic [31:0] SRAM_Q;

    int checks   = 0;
    int failures = 0;

    // SRAM model, with a bench-side preload port
    logic [31:0] mem [256];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_a  = '0;
    logic [31:0] pre_d  = '0;
    int          we_cnt  = 0;
    int          rsp_cnt = 0;

    always #5 CK = ~CK;

    synaptic_sram_rmw_ctrl dut (
        .CK(CK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_ADDR(REQ_ADDR), .REQ_LANE(REQ_LANE), .REQ_DELTA(REQ_DELTA),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
        .SRAM_CS(SRAM_CS), .SRAM_WE(SRAM_WE), .SRAM_A(SRAM_A),
        .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
    );

    always @(posedge CK) begin
        if (pre_en) begin
            mem[pre_a] <= pre_d;
        end else if (SRAM_CS) begin
            if (SRAM_WE) mem[SRAM_A] <= SRAM_D;
            else         SRAM_Q <= mem[SRAM_A];
        end
        if (SRAM_CS && SRAM_WE) we_cnt <= we_cnt + 1;
        if (RSP_VALID)          rsp_cnt <= rsp_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge CK);
        pre_en = 1'b1; pre_a = a; pre_d = d;
        @(negedge CK);
        pre_en = 1'b0;
    endtask

    // Issue one request and watch 12 negedges for its response.
    task automatic do_req(input logic op, input logic [7:0] addr, input logic [1:0] lane,
                          input logic [7:0] delta, output logic [31:0] data, output int lat,
                          output bit got, output int pulses, output int writes);
        int rsp0, we0;
        got = 0; lat = -1; data = '0;
        @(negedge CK);
        rsp0 = rsp_cnt; we0 = we_cnt;
        REQ_VALID = 1'b1; REQ_OP = op; REQ_ADDR = addr; REQ_LANE = lane; REQ_DELTA = delta;
        @(posedge CK);
        for (int k = 0; k < 12; k++) begin
            @(negedge CK);
            if (k == 0) REQ_VALID = 1'b0;
            if (RSP_VALID && !got) begin
                got = 1; lat = k + 1; data = RSP_DATA;
            end
        end
        pulses = rsp_cnt - rsp0;
        writes = we_cnt - we0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(negedge CK);
        checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", REQ_READY); end
        checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", RSP_VALID); end
        checks++; if (RSP_DATA !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", RSP_DATA); end
        checks++; if (SRAM_CS !== 1'b0) begin failures++; $display("FAIL reset_cs got=%b exp=0", SRAM_CS); end
        checks++; if (SRAM_WE !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", SRAM_WE); end
        checks++; if (SRAM_A !== 8'h0) begin failures++; $display("FAIL reset_a got=%h exp=0", SRAM_A); end
        checks++; if (SRAM_D !== 32'h0) begin failures++; $display("FAIL reset_d got=%h exp=0", SRAM_D); end
        RST = 1'b0;
        @(negedge CK);
    endtask

    task automatic test_read;
        logic [31:0] d; int lat, pulses, writes; bit got;
        preload(8'h05, 32'h11223344);
        do_req(1'b0, 8'h05, 2'd0, 8'd0, d, lat, got, pulses, writes);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL read_got got=%b exp=1", got); end
        checks++; if (lat != 3) begin failures++; $display("FAIL read_latency got=%0d exp=3", lat); end
        checks++; if (d !== 32'h11223344) begin failures++; $display("FAIL read_data got=%h exp=11223344", d); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL read_pulses got=%0d exp=1", pulses); end
        checks++; if (writes != 0) begin failures++; $display("FAIL read_no_write got=%0d exp=0", writes); end
    endtask

    // One update: check response data, latency, single pulse, single write and the final SRAM word.
    task automatic test_update(input string name, input logic [7:0] addr, input logic [31:0] init,
                               input logic [1:0] lane, input logic [7:0] delta, input logic [31:0] exp);
        logic [31:0] d; int lat, pulses, writes; bit got;
        preload(addr, init);
        do_req(1'b1, addr, lane, delta, d, lat, got, pulses, writes);
        checks++; if (d !== exp) begin failures++; $display("FAIL %s_rsp got=%h exp=%h", name, d, exp); end
        checks++; if (mem[addr] !== exp) begin failures++; $display("FAIL %s_mem got=%h exp=%h", name, mem[addr], exp); end
        checks++; if (lat != 4) begin failures++; $display("FAIL %s_latency got=%0d exp=4", name, lat); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL %s_pulses got=%0d exp=1", name, pulses); end
        checks++; if (writes != 1) begin failures++; $display("FAIL %s_writes got=%0d exp=1", name, writes); end
    endtask

    task automatic test_updates;
        test_update("sat_pos",  8'h10, 32'h00000078, 2'd0, 8'd20,  32'h0000007F); // 120+20 -> 127
        test_update("sat_neg",  8'h20, 32'h9C000000, 2'd3, 8'hCE,  32'h80000000); // -100-50 -> -128
        test_update("lane2",    8'hFF, 32'h01020304, 2'd2, 8'hFD,  32'h01FF0304); // 2-3 -> -1
        test_update("delta0",   8'h30, 32'hA5A5A5A5, 2'd1, 8'h00,  32'hA5A5A5A5);
        test_update("min_plus", 8'h40, 32'h00008000, 2'd1, 8'h7F,  32'h0000FF00); // -128+127 -> -1
        test_update("to_max",   8'h41, 32'h7E7E7E7E, 2'd3, 8'h01,  32'h7F7E7E7E); // 126+1 -> 127
    endtask

    task automatic test_back_to_back;
        int acc_t [2]; int rsp_t [2]; logic [31:0] rsp_d [2];
        int nacc = 0, nrsp = 0, low_cnt = 0, rsp0;
        bit accepting;
        acc_t = '{-1, -1}; rsp_t = '{-1, -1}; rsp_d = '{32'h0, 32'h0};
        preload(8'h50, 32'hDEADBEEF);
        preload(8'h51, 32'h00000001);
        @(negedge CK);
        rsp0 = rsp_cnt;
        REQ_VALID = 1'b1; REQ_OP = 1'b0; REQ_ADDR = 8'h50; REQ_LANE = 2'd0; REQ_DELTA = 8'd0;
        for (int c = 0; c < 20; c++) begin
            if (RSP_VALID && nrsp < 2) begin rsp_d[nrsp] = RSP_DATA; rsp_t[nrsp] = c; nrsp++; end
            if (!REQ_READY) low_cnt++;
            accepting = REQ_VALID && REQ_READY && (nacc < 2);
            if (accepting) begin acc_t[nacc] = c; nacc++; end
            @(negedge CK);
            if (accepting) begin
                if (nacc == 1) begin REQ_OP = 1'b1; REQ_ADDR = 8'h51; REQ_LANE = 2'd0; REQ_DELTA = 8'd5; end
                else REQ_VALID = 1'b0;
            end
        end
        checks++; if (acc_t[0] != 0) begin failures++; $display("FAIL b2b_acc0 got=%0d exp=0", acc_t[0]); end
        checks++; if (acc_t[1] != 4) begin failures++; $display("FAIL b2b_acc1 got=%0d exp=4", acc_t[1]); end
        checks++; if (low_cnt != 7) begin failures++; $display("FAIL b2b_ready_low got=%0d exp=7", low_cnt); end
        checks++; if (rsp_t[0] != 3 || rsp_d[0] !== 32'hDEADBEEF)
            begin failures++; $display("FAIL b2b_rsp0 got=%0d/%h exp=3/deadbeef", rsp_t[0], rsp_d[0]); end
        checks++; if (rsp_t[1] != 8 || rsp_d[1] !== 32'h00000006)
            begin failures++; $display("FAIL b2b_rsp1 got=%0d/%h exp=8/00000006", rsp_t[1], rsp_d[1]); end
        checks++; if (rsp_cnt - rsp0 != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", rsp_cnt - rsp0); end
        checks++; if (mem[8'h51] !== 32'h00000006) begin failures++; $display("FAIL b2b_mem got=%h exp=00000006", mem[8'h51]); end
    endtask

    task automatic test_reset_mid;
        int rsp0, we0;
        preload(8'h60, 32'h12345678);
        @(negedge CK);
        rsp0 = rsp_cnt; we0 = we_cnt;
        REQ_VALID = 1'b1; REQ_OP = 1'b1; REQ_ADDR = 8'h60; REQ_LANE = 2'd0; REQ_DELTA = 8'd1;
        @(posedge CK);
        @(negedge CK);                         // READ
        REQ_VALID = 1'b0;
        checks++; if (SRAM_CS !== 1'b1) begin failures++; $display("FAIL rmid_read_cs got=%b exp=1", SRAM_CS); end
        @(negedge CK);                         // CALC
        checks++; if (SRAM_CS !== 1'b0 || REQ_READY !== 1'b0)
            begin failures++; $display("FAIL rmid_calc got=cs%b/rdy%b exp=cs0/rdy0", SRAM_CS, REQ_READY); end
        RST = 1'b1;
        @(negedge CK);
        checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", REQ_READY); end
        checks++; if (SRAM_CS !== 1'b0 || SRAM_WE !== 1'b0)
            begin failures++; $display("FAIL rmid_cs_we got=%b%b exp=00", SRAM_CS, SRAM_WE); end
        checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("FAIL rmid_rsp_valid got=%b exp=0", RSP_VALID); end
        RST = 1'b0;
        repeat (6) @(negedge CK);
        checks++; if (we_cnt - we0 != 0) begin failures++; $display("FAIL rmid_writes got=%0d exp=0", we_cnt - we0); end
        checks++; if (rsp_cnt - rsp0 != 0) begin failures++; $display("FAIL rmid_pulses got=%0d exp=0", rsp_cnt - rsp0); end
        checks++; if (mem[8'h60] !== 32'h12345678) begin failures++; $display("FAIL rmid_mem got=%h exp=12345678", mem[8'h60]); end
    endtask

    initial begin
        RST = 1'b1; REQ_VALID = 1'b0; REQ_OP = 1'b0; REQ_ADDR = '0; REQ_LANE = '0; REQ_DELTA = '0;
        test_reset();
        test_read();
        test_updates();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
